// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the mandelbrot pixel distribution logic.
package mandelbrot_pkg;

  localparam int PIXEL_DATA_WIDTH  = 10;
  localparam int ENGINE_DATA_WIDTH = 25;
  localparam int NUM_ENGINES       = 4;
  localparam int ZOOM_WIDTH        = 3;
  localparam int X_SIZE            = 640;
  localparam int Y_SIZE            = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dist_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first eligible request after the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] eligible;
  int unsigned        pos;

  // Scan from ptr+1 around the ring and take the first eligible requester.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    pos      = 0;
    eligible = req_i & ~mask_i;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && eligible[pos]) begin
        valid_o      = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/pixel_distributor.sv
// Hands out frame pixels in raster order to requesting mandelbrot engines,
// one registered grant per cycle, with frame-latched view parameters.
module pixel_distributor #(
  parameter int PIXEL_DATA_WIDTH  = mandelbrot_pkg::PIXEL_DATA_WIDTH,
  parameter int ENGINE_DATA_WIDTH = mandelbrot_pkg::ENGINE_DATA_WIDTH,
  parameter int NUM_ENGINES       = mandelbrot_pkg::NUM_ENGINES,
  parameter int X_SIZE            = mandelbrot_pkg::X_SIZE,
  parameter int Y_SIZE            = mandelbrot_pkg::Y_SIZE
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                full_queue,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_in,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_in,
  input  logic [2:0]                          zoom_in,
  input  logic [NUM_ENGINES-1:0]              engine_req,
  output logic [NUM_ENGINES-1:0]              grant,
  output logic [PIXEL_DATA_WIDTH-1:0]         x0_,
  output logic [PIXEL_DATA_WIDTH-1:0]         y0_,
  output logic signed [ENGINE_DATA_WIDTH-1:0] x_offset,
  output logic signed [ENGINE_DATA_WIDTH-1:0] y_offset,
  output logic [2:0]                          zoom,
  output logic                                busy,
  output logic                                frame_done
);

  import mandelbrot_pkg::*;

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(X_SIZE - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(Y_SIZE - 1);
  localparam logic [IDX_W-1:0]            PTR_RST = IDX_W'(NUM_ENGINES - 1);

  dist_state_e                          state_q, state_d;
  logic [PIXEL_DATA_WIDTH-1:0]          x_cnt_q, x_cnt_d;
  logic [PIXEL_DATA_WIDTH-1:0]          y_cnt_q, y_cnt_d;
  logic [IDX_W-1:0]                     ptr_q, ptr_d;
  logic [NUM_ENGINES-1:0]               grant_q, grant_d;
  logic [PIXEL_DATA_WIDTH-1:0]          x0_q, x0_d;
  logic [PIXEL_DATA_WIDTH-1:0]          y0_q, y0_d;
  logic signed [ENGINE_DATA_WIDTH-1:0]  xoff_q, xoff_d;
  logic signed [ENGINE_DATA_WIDTH-1:0]  yoff_q, yoff_d;
  logic [2:0]                           zoom_q, zoom_d;
  logic                                 fdone_q, fdone_d;

  logic [NUM_ENGINES-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;

  // Last cycle's grant is masked so an engine whose request is still
  // falling cannot be served twice.
  rr_arbiter #(
    .NUM_REQ (NUM_ENGINES),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (engine_req),
    .mask_i  (grant_q),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Next-state logic: frame start latching, pixel issue and raster stepping.
  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    x0_d    = x0_q;
    y0_d    = y0_q;
    xoff_d  = xoff_q;
    yoff_d  = yoff_q;
    zoom_d  = zoom_q;
    fdone_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          x_cnt_d = '0;
          y_cnt_d = '0;
          xoff_d  = x_offset_in;
          yoff_d  = y_offset_in;
          zoom_d  = zoom_in;
        end
      end
      ST_RUN: begin
        if (!full_queue && arb_valid) begin
          grant_d = arb_grant;
          x0_d    = x_cnt_q;
          y0_d    = y_cnt_q;
          ptr_d   = arb_idx;
          if (x_cnt_q == X_LAST) begin
            x_cnt_d = '0;
            if (y_cnt_q == Y_LAST) begin
              y_cnt_d = '0;
              state_d = ST_DONE;
            end else begin
              y_cnt_d = y_cnt_q + 1'b1;
            end
          end else begin
            x_cnt_d = x_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        fdone_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      ptr_q   <= PTR_RST;
      grant_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      xoff_q  <= '0;
      yoff_q  <= '0;
      zoom_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xoff_q  <= xoff_d;
      yoff_q  <= yoff_d;
      zoom_q  <= zoom_d;
      fdone_q <= fdone_d;
    end
  end

  assign grant      = grant_q;
  assign x0_        = x0_q;
  assign y0_        = y0_q;
  assign x_offset   = xoff_q;
  assign y_offset   = yoff_q;
  assign zoom       = zoom_q;
  assign busy       = (state_q == ST_RUN);
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_pixel_distributor.sv
// Scoreboard bench for pixel_distributor on a reduced 8x3 frame.
module tb_pixel_distributor;

  localparam int PW = 10;
  localparam int EW = 25;
  localparam int NE = 4;
  localparam int XS = 8;
  localparam int YS = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 full_queue;
  logic signed [EW-1:0] x_offset_in;
  logic signed [EW-1:0] y_offset_in;
  logic [2:0]           zoom_in;
  logic [NE-1:0]        engine_req;
  logic [NE-1:0]        grant;
  logic [PW-1:0]        x0_;
  logic [PW-1:0]        y0_;
  logic signed [EW-1:0] x_offset;
  logic signed [EW-1:0] y_offset;
  logic [2:0]           zoom;
  logic                 busy;
  logic                 frame_done;

  pixel_distributor #(
    .PIXEL_DATA_WIDTH  (PW),
    .ENGINE_DATA_WIDTH (EW),
    .NUM_ENGINES       (NE),
    .X_SIZE            (XS),
    .Y_SIZE            (YS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .full_queue  (full_queue),
    .x_offset_in (x_offset_in),
    .y_offset_in (y_offset_in),
    .zoom_in     (zoom_in),
    .engine_req  (engine_req),
    .grant       (grant),
    .x0_         (x0_),
    .y0_         (y0_),
    .x_offset    (x_offset),
    .y_offset    (y_offset),
    .zoom        (zoom),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned x;
    int unsigned y;
  } pix_t;

  pix_t pix_q[$];
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  int   last_gcyc = 0;
  int   n_grants  = 0;
  int   fd_cnt    = 0;
  int   exp_eng   = 0;
  bit   single    = 1'b0;
  bit   have_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++)
        pix_q.push_back('{x: x, y: y});
    have_prev = 1'b0;
  endtask

  // Advance one clock, sample 1ns later and score any grant / frame_done.
  task automatic tick();
    pix_t          e;
    logic [NE-1:0] eg;
    @(posedge clk);
    #1;
    cyc++;
    if (grant != '0) begin
      n_grants++;
      if (pix_q.size() == 0) begin
        chk("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = pix_q.pop_front();
        chk("x0", 32'(x0_), e.x);
        chk("y0", 32'(y0_), e.y);
      end
      eg = NE'(1) << exp_eng;
      chk("grant_onehot", 32'(grant), 32'(eg));
      if (!single) exp_eng = (exp_eng + 1) % NE;
      if (single && have_prev) chk("single_gap", cyc - last_gcyc, 2);
      have_prev = 1'b1;
      last_gcyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      chk("fd_latency", cyc - last_gcyc, 1);
      chk("fd_pending_pixels", pix_q.size(), 0);
    end
  endtask

  task automatic run_frame(input int limit);
    int fd0;
    int k;
    fd0 = fd_cnt;
    k   = 0;
    while (fd_cnt == fd0 && k < limit) begin
      tick();
      k++;
    end
    chk("frame_done_seen", fd_cnt - fd0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_x0"}, 32'(x0_), 32'd0);
    chk({tag, "_y0"}, 32'(y0_), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
    chk({tag, "_xoff"}, 32'(x_offset), 32'd0);
    chk({tag, "_yoff"}, 32'(y_offset), 32'd0);
    chk({tag, "_zoom"}, 32'(zoom), 32'd0);
  endtask

  initial begin
    int fd0;
    int g0;
    int k;
    logic signed [EW-1:0] exp_xoff;

    reset       = 1'b1;
    start       = 1'b0;
    full_queue  = 1'b0;
    x_offset_in = '0;
    y_offset_in = '0;
    zoom_in     = '0;
    engine_req  = '0;
    #1;
    check_reset_vals("por");
    tick();
    tick();
    reset = 1'b0;

    // Single engine holding its request: grants every other cycle.
    single      = 1'b1;
    exp_eng     = 0;
    x_offset_in = 25'sh0012345;
    y_offset_in = -25'sd5;
    zoom_in     = 3'd3;
    engine_req  = 4'b0001;
    start       = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    chk("run_busy", 32'(busy), 32'd1);
    chk("latch_xoff", 32'(x_offset), 32'(25'sh0012345));
    chk("latch_yoff", 32'(y_offset), 32'(-25'sd5));
    chk("latch_zoom", 32'(zoom), 32'd3);
    run_frame(200);
    tick();
    chk("fd_one_cycle", 32'(frame_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("frameA_drained", pix_q.size(), 0);

    // All four engines, with a stall, a request gap, a mid-frame offset
    // change and an ignored start.
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    single     = 1'b0;
    exp_eng    = 0;
    engine_req = '1;
    exp_xoff    = 25'sh0001000;
    x_offset_in = exp_xoff;
    start       = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    chk("latch_xoff_B", 32'(x_offset), 32'(exp_xoff));
    fd0 = fd_cnt;
    k   = 0;
    while (fd_cnt == fd0 && k < 200) begin
      tick();
      k++;
      if (grant != '0 && x0_ == 2 && y0_ == 0) begin
        full_queue = 1'b1;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_grant", 32'(grant), 32'd0);
        end
        full_queue = 1'b0;
      end else if (grant != '0 && x0_ == 5 && y0_ == 0) begin
        x_offset_in = 25'sh0100000;
        start       = 1'b1;
        engine_req  = '0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("noreq_grant", 32'(grant), 32'd0);
          chk("xoff_held", 32'(x_offset), 32'(exp_xoff));
        end
        start      = 1'b0;
        engine_req = '1;
      end
    end
    chk("frameB_done", fd_cnt - fd0, 1);
    chk("xoff_held_end", 32'(x_offset), 32'(exp_xoff));

    // New offset taken at the next start; reset after three grants.
    tick();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    chk("latch_xoff_C", 32'(x_offset), 32'(25'sh0100000));
    g0 = n_grants;
    k  = 0;
    while (n_grants - g0 < 3 && k < 20) begin
      tick();
      k++;
    end
    chk("abort_grants", n_grants - g0, 3);
    fd0   = fd_cnt;
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    pix_q.delete();
    tick();
    chk("abort_fd0", 32'(frame_done), 32'd0);
    tick();
    chk("abort_fd1", 32'(frame_done), 32'd0);
    reset   = 1'b0;
    exp_eng = 0;
    start   = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    run_frame(200);
    chk("abort_single_fd", fd_cnt - fd0, 1);

    // start held high: back-to-back frames, each with XS*YS grants.
    tick();
    start = 1'b1;
    push_frame();
    g0 = n_grants;
    run_frame(100);
    chk("frame_grants_1", n_grants - g0, XS * YS);
    push_frame();
    g0 = n_grants;
    run_frame(100);
    chk("frame_grants_2", n_grants - g0, XS * YS);
    start = 1'b0;
    tick();
    tick();
    chk("final_idle", 32'(busy), 32'd0);
    chk("final_drained", pix_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_distributor.md
PIXEL_DISTRIBUTOR -- requirements
Module: pixel_distributor

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- PIXEL_DATA_WIDTH, 10, pixel coordinate width.
- ENGINE_DATA_WIDTH, 25, signed offset width (5.20 fixed point).
- NUM_ENGINES, 4, number of mandelbrot engines served.
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, begin frame (level-sampled in IDLE only).
- full_queue, in, 1, downstream result queue full; stalls issue.
- x_offset_in, in, ENGINE_DATA_WIDTH signed, requested x offset.
- y_offset_in, in, ENGINE_DATA_WIDTH signed, requested y offset.
- zoom_in, in, 3, requested zoom.
- engine_req, in, NUM_ENGINES, engine i requests a pixel.
- grant, out, NUM_ENGINES, one-hot or zero; pixel transfer strobe.
- x0_, out, PIXEL_DATA_WIDTH, pixel x of current grant.
- y0_, out, PIXEL_DATA_WIDTH, pixel y of current grant.
- x_offset, out, ENGINE_DATA_WIDTH signed, frame-latched offset.
- y_offset, out, ENGINE_DATA_WIDTH signed, frame-latched offset.
- zoom, out, 3, frame-latched zoom.
- busy, out, 1, high in RUN.
- frame_done, out, 1, one-cycle pulse after last pixel issued.

Function
REQ-003 States SHALL be IDLE, RUN, DONE.
REQ-004 IDLE -> RUN when start=1; x_offset_in, y_offset_in, zoom_in SHALL be latched on that edge and held stable until the next IDLE -> RUN.
REQ-005 Pixel counters SHALL be cleared to (0,0) on IDLE -> RUN.
REQ-006 In RUN, each cycle with full_queue=0 and at least one eligible engine_req bit, exactly one engine SHALL be granted by round-robin starting at (last granted index + 1) mod NUM_ENGINES.
REQ-007 The engine granted in the previous cycle SHALL be ineligible this cycle (prevents double issue while its engine_req falls).
REQ-008 grant, x0_, y0_ SHALL be registered; grant is a one-cycle pulse and x0_/y0_ hold the pixel belonging to that pulse; a transfer occurs on every cycle grant[i]=1.
REQ-009 Pixels SHALL be issued in raster order: x increments 0..X_SIZE-1, wraps to 0 and increments y, up to (X_SIZE-1, Y_SIZE-1).
REQ-010 full_queue=1 SHALL suppress new grants from the next edge; no pixel is skipped or repeated across a stall.
REQ-011 Issuing (X_SIZE-1, Y_SIZE-1) SHALL move RUN -> DONE; DONE SHALL assert frame_done for exactly one cycle and return to IDLE.
REQ-012 start while in RUN or DONE SHALL be ignored.
REQ-013 No engine_req and full_queue=0 SHALL leave counters and the round-robin pointer unchanged.
REQ-014 Each pixel of a frame SHALL be granted exactly once: X_SIZE*Y_SIZE grants per frame.

Reset
REQ-015 reset=1 SHALL asynchronously force: state IDLE, grant=0, x0_=0, y0_=0, busy=0, frame_done=0, x_offset=0, y_offset=0, zoom=0, counters 0, round-robin pointer to NUM_ENGINES-1 (first grant favours engine 0).
REQ-016 Reset mid-frame SHALL abandon the frame with no frame_done; the next start restarts at (0,0).

Structure
REQ-017 mandelbrot_pkg SHALL hold PIXEL_DATA_WIDTH, ENGINE_DATA_WIDTH, X_SIZE, Y_SIZE and the distributor state enum.
REQ-018 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, mask, pointer -> one-hot grant, index).

Verification
REQ-019 Single engine, engine_req[0] held high, X_SIZE=4, Y_SIZE=2 -> grants on alternate cycles, pixels (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), frame_done one cycle after last.
REQ-020 Four engines, all requesting -> grant order 0001,0010,0100,1000,0001; x0_ 0,1,2,3,4.
REQ-021 full_queue=1 for 5 cycles after pixel (2,0) -> no grant during stall; next grant carries (3,0).
REQ-022 Offsets changed to 0x0100000 mid-frame -> x_offset output unchanged until next start.
REQ-023 reset asserted after 3 grants -> outputs at REQ-015 values immediately; after start, first pixel is (0,0), no frame_done from the aborted frame.
REQ-024 start held high through a whole 640x480 frame -> exactly 307200 grants, then a new frame begins after DONE.
